// File: rtl/uart_rx_frame_if.sv
// Receive-side UART bundle: serial line and baud-pulse inputs plus the byte-level results.
// The receiver uses the master modport; the consumer/stimulus side uses slave.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 pulse_rx;
  logic                 rx_val;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    input  rx,
    input  pulse_rx,
    output rx_val,
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err
  );

  modport slave (
    output rx,
    output pulse_rx,
    input  rx_val,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver driven by the baud generator's pulse_rx stream; delivers one byte per frame.
// Define UART_PARITY_EN to add a parity bit between data and stop (parity_err is tied 0 otherwise).
module uart_rx_frame #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY_ODD    = 0,
  parameter int PULSE_TIMEOUT = 2000
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_frame_if.master bus
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int TMO_W = $clog2(PULSE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PULSE_TIMEOUT - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_frame: DATA_BITS must be 5..8");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_q;
  logic                 pulse_q;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 rx_val_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 ferr_r;
  logic                 fall;
  logic                 pedge;
  logic                 tmo_hit;

  // rx is asynchronous; the extra rx_q stage gives a clean one-cycle falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
      pulse_q <= bus.pulse_rx;
    end
  end

  assign fall    = rx_q & ~rx_s;
  assign pedge   = bus.pulse_rx & ~pulse_q;
  assign tmo_hit = (state != IDLE) && !pedge && (tmo_cnt == TMO_LAST);

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);
  logic par_bit;
  logic perr_r;
`endif

  // A pedge always wins over an expiring timeout because tmo_hit already excludes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      tmo_cnt  <= '0;
      rx_val_r <= 1'b0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      ferr_r   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
      perr_r   <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
`ifdef UART_PARITY_EN
      perr_r  <= 1'b0;
`endif
      if (state == IDLE || pedge) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (tmo_hit) begin
        state    <= IDLE;
        rx_val_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state    <= START;
              rx_val_r <= 1'b1;
            end
          end
          START: begin
            if (pedge) begin
              if (rx_s) begin
                state    <= IDLE;
                rx_val_r <= 1'b0;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
          end
          DATA: begin
            if (pedge) begin
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            if (pedge) begin
              par_bit <= rx_s;
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            if (pedge) begin
              data_r   <= shift;
              valid_r  <= 1'b1;
              ferr_r   <= ~rx_s;
              rx_val_r <= 1'b0;
              state    <= IDLE;
`ifdef UART_PARITY_EN
              perr_r   <= (^shift) ^ par_bit ^ PAR_ODD_BIT;
`endif
            end
          end
          default: begin
            state    <= IDLE;
            rx_val_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_val     = rx_val_r;
  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign bus.frame_err  = ferr_r;
`ifdef UART_PARITY_EN
  assign bus.parity_err = perr_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized bench for uart_rx_frame: a simple baud-pulse driver, a strobe monitor and a frame-level
// reference model. Parity scenarios are added when UART_PARITY_EN is defined.
module tb_uart_rx_frame;

  localparam int DB   = 8;
  localparam int PODD = 0;
  localparam int TMO  = 2000;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  logic clk;
  logic rst_n;

  uart_rx_frame_if #(.DATA_BITS(DB)) bus ();

  uart_rx_frame #(
    .DATA_BITS(DB),
    .PARITY_ODD(PODD),
    .PULSE_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  rec_t       obs_q[$];
  rec_t       exp_q[$];
  rec_t       mon_r;
  int         n_cmp = 0;
  int         n_err = 0;
  int         rxval_low = 0;
  int         rv_hi_at_strobe = 0;
  logic [7:0] exp_last = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every data_valid cycle becomes one observed record; a two-cycle strobe shows up as two records
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      mon_r.data = bus.data_out;
      mon_r.ferr = bus.frame_err;
      mon_r.perr = bus.parity_err;
      obs_q.push_back(mon_r);
      if (bus.rx_val !== 1'b0) rv_hi_at_strobe++;
    end
  end

  function automatic rec_t model(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    rec_t r;
    r.data = d;
    r.ferr = ~stop_bit;
    r.perr = PAR_EN ? (((^d) ^ par_bit) != 1'(PODD)) : 1'b0;
    return r;
  endfunction

  function automatic logic good_parity(input logic [7:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit period: the line settles, then a 10-clock pulse_rx starts at mid-bit
  task automatic drive_bit(input logic b, input int bit_clk);
    bus.rx = b;
    wait_clks(bit_clk / 2);
    if (bus.rx_val !== 1'b1) rxval_low++;
    bus.pulse_rx = 1'b1;
    wait_clks(10);
    bus.pulse_rx = 1'b0;
    wait_clks(bit_clk - bit_clk / 2 - 10);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                             input int bit_clk, input int idle_clks);
    bus.rx = 1'b1;
    if (idle_clks > 0) wait_clks(idle_clks);
    drive_bit(1'b0, bit_clk);
    for (int i = 0; i < DB; i++) drive_bit(d[i], bit_clk);
    if (PAR_EN) drive_bit(par_bit, bit_clk);
    drive_bit(stop_bit, bit_clk);
  endtask

  task automatic push_expected(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    exp_q.push_back(model(d, stop_bit, par_bit));
    exp_last = d;
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    bus.pulse_rx = 1'b0;
    rst_n = 1'b0;
    wait_clks(5);
    n_cmp++;
    if ({bus.rx_val, bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err} !== 12'h000) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got rx_val=%b data=%h dv=%b fe=%b pe=%b, expected all 0",
               bus.rx_val, bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err);
    end
    rst_n = 1'b1;
    wait_clks(50);
    n_cmp++;
    if (obs_q.size() != 0 || bus.rx_val !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_idle: got %0d strobes rx_val=%b, expected 0 strobes rx_val=0",
               obs_q.size(), bus.rx_val);
    end
    obs_q.delete();
  endtask

  task automatic test_clean_frame();
    rec_t o;
    rxval_low = 0;
    rv_hi_at_strobe = 0;
    push_expected(8'hA5, 1'b1, good_parity(8'hA5));
    drive_frame(8'hA5, 1'b1, good_parity(8'hA5), 868, 20);
    wait_clks(5);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("[TB] FAIL clean_count: got %0d strobes, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (o.data !== 8'hA5 || o.ferr !== 1'b0 || o !== exp_q[0]) begin
        n_err++;
        $display("[TB] FAIL clean_frame: got data=%h fe=%b pe=%b, expected data=a5 fe=0 pe=0",
                 o.data, o.ferr, o.perr);
      end
    end
    n_cmp++;
    if (rxval_low != 0) begin
      n_err++;
      $display("[TB] FAIL clean_rx_val_high: rx_val low at %0d bit samples, expected 0", rxval_low);
    end
    n_cmp++;
    if (rv_hi_at_strobe != 0 || bus.rx_val !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL clean_rx_val_drop: rx_val high at %0d strobes, now %b, expected 0/0",
               rv_hi_at_strobe, bus.rx_val);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_frames();
    rec_t o, e;
    logic [7:0] d;
    logic s, p;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      s = 1'($urandom_range(0, 3) != 0);
      p = 1'($urandom_range(0, 1));
      push_expected(d, s, p);
      drive_frame(d, s, p, 40, 10);
    end
    wait_clks(5);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("[TB] FAIL random_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("[TB] FAIL random_frame: got data=%h fe=%b pe=%b, expected data=%h fe=%b pe=%b",
                 o.data, o.ferr, o.perr, e.data, e.ferr, e.perr);
      end
    end
    obs_q.delete();
    exp_q.delete();
    bus.rx = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_false_start();
    bus.rx = 1'b0;
    wait_clks(200);
    bus.rx = 1'b1;
    wait_clks(234);
    n_cmp++;
    if (bus.rx_val !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL false_start_armed: rx_val=%b, expected 1", bus.rx_val);
    end
    bus.pulse_rx = 1'b1;
    wait_clks(10);
    bus.pulse_rx = 1'b0;
    n_cmp++;
    if (bus.rx_val !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL false_start_abort: rx_val=%b, expected 0", bus.rx_val);
    end
    wait_clks(424);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL false_start_strobe: got %0d strobes, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_framing_error();
    rec_t o, e;
    push_expected(8'h3C, 1'b0, good_parity(8'h3C));
    drive_frame(8'h3C, 1'b0, good_parity(8'h3C), 100, 20);
    wait_clks(5);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("[TB] FAIL ferr_count: got %0d strobes, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e || o.ferr !== 1'b1 || o.data !== 8'h3C) begin
        n_err++;
        $display("[TB] FAIL ferr_frame: got data=%h fe=%b pe=%b, expected data=3c fe=1 pe=%b",
                 o.data, o.ferr, o.perr, e.perr);
      end
    end
    obs_q.delete();
    exp_q.delete();
    // line still low: pulses must not start anything
    rxval_low = 0;
    drive_bit(1'b0, 100);
    drive_bit(1'b0, 100);
    n_cmp++;
    if (rxval_low != 2 || obs_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL ferr_stuck_low: rx_val low at %0d of 2 samples, %0d strobes, expected 2/0",
               rxval_low, obs_q.size());
    end
    obs_q.delete();
    push_expected(8'h5A, 1'b1, good_parity(8'h5A));
    drive_frame(8'h5A, 1'b1, good_parity(8'h5A), 100, 20);
    wait_clks(5);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_err++;
      $display("[TB] FAIL ferr_recover: got %0d strobes data=%h, expected 1 strobe data=5a",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int hi_cnt;
    int guard;
    bus.rx = 1'b0;
    guard = 0;
    while (bus.rx_val !== 1'b1 && guard < 50) begin
      wait_clks(1);
      guard++;
    end
    n_cmp++;
    if (bus.rx_val !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL timeout_arm: rx_val=%b after 50 clks, expected 1", bus.rx_val);
    end
    hi_cnt = 0;
    while (bus.rx_val === 1'b1 && hi_cnt < 3000) begin
      hi_cnt++;
      wait_clks(1);
    end
    n_cmp++;
    if (hi_cnt != 2000) begin
      n_err++;
      $display("[TB] FAIL timeout_len: rx_val high %0d clks, expected 2000", hi_cnt);
    end
    n_cmp++;
    if (obs_q.size() != 0 || bus.data_out !== exp_last) begin
      n_err++;
      $display("[TB] FAIL timeout_no_strobe: %0d strobes data=%h, expected 0 strobes data=%h",
               obs_q.size(), bus.data_out, exp_last);
    end
    obs_q.delete();
    bus.rx = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      push_expected(d, 1'b1, good_parity(d));
      drive_frame(d, 1'b1, good_parity(d), 40, (i == 0) ? 10 : 0);
    end
    wait_clks(5);
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_err++;
      $display("[TB] FAIL b2b_count: got %0d strobes, expected 3", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("[TB] FAIL b2b_frame: got data=%h fe=%b, expected data=%h fe=%b",
                 o.data, o.ferr, e.data, e.ferr);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 100);
    bus.rx = 1'b0;
    wait_clks(30);
    rst_n = 1'b0;
    wait_clks(3);
    n_cmp++;
    if ({bus.rx_val, bus.data_out, bus.data_valid, bus.frame_err, bus.parity_err} !== 12'h000) begin
      n_err++;
      $display("[TB] FAIL midreset_outputs: got rx_val=%b data=%h dv=%b fe=%b, expected all 0",
               bus.rx_val, bus.data_out, bus.data_valid, bus.frame_err);
    end
    bus.rx = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    exp_last = 8'h00;
    wait_clks(300);
    n_cmp++;
    if (obs_q.size() != 0 || bus.rx_val !== 1'b0 || bus.data_out !== exp_last) begin
      n_err++;
      $display("[TB] FAIL midreset_idle: %0d strobes rx_val=%b data=%h, expected 0/0/00",
               obs_q.size(), bus.rx_val, bus.data_out);
    end
    obs_q.delete();
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    rec_t o;
    logic [1:0] want;
    for (int i = 0; i < 2; i++) begin
      want[i] = model(8'h07, 1'b1, 1'(1 - i)).perr;
      drive_frame(8'h07, 1'b1, 1'(1 - i), 100, 20);
      wait_clks(5);
      n_cmp++;
      if (obs_q.size() != 1) begin
        n_err++;
        $display("[TB] FAIL parity_count: got %0d strobes, expected 1", obs_q.size());
      end else begin
        o = obs_q.pop_front();
        n_cmp++;
        if (o.perr !== want[i] || o.perr !== 1'(i) || o.data !== 8'h07) begin
          n_err++;
          $display("[TB] FAIL parity_err: got data=%h pe=%b, expected data=07 pe=%0d",
                   o.data, o.perr, i);
        end
      end
      obs_q.delete();
    end
    exp_last = 8'h07;
  endtask
`endif

  initial begin
    #800us;
    n_err++;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    test_reset();
    test_clean_frame();
    test_random_frames();
    test_false_start();
    test_framing_error();
    test_timeout();
    test_back_to_back();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
